// File: rtl/alu_commit_arbiter.sv
// alu_commit_arbiter: merges ALU sub-unit commit streams onto one
// registered commit port, round-robin with a starvation override.
module alu_commit_arbiter #(
    parameter int NUM_INPUTS = 2,
    parameter int DATAW      = 64,
    parameter int MAX_WAIT   = 8,
    parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0] data_in,
    output logic [NUM_INPUTS-1:0]       ready_in,
    output logic                        valid_out,
    output logic [DATAW-1:0]            data_out,
    input  logic                        ready_out,
    output logic [SEL_W-1:0]            sel_out,
    output logic                        starve_out
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [SEL_W-1:0]      ptr;
    logic [CNT_W-1:0]      wait_cnt [NUM_INPUTS];
    logic                  can_accept;
    logic                  found;
    logic                  any_grant;
    logic                  ovr_hit;
    logic [NUM_INPUTS-1:0] grant;
    logic [SEL_W-1:0]      grant_idx;
    logic [SEL_W-1:0]      ptr_nxt;
    logic [DATAW-1:0]      data_sel;

    assign can_accept = ~valid_out | ready_out;
    assign ready_in   = grant;
    assign ptr_nxt    = (grant_idx == SEL_W'(NUM_INPUTS - 1))
                      ? '0 : grant_idx + 1'b1;

    // Winner: lowest starved input, else first valid scanning from ptr
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        ovr_hit   = 1'b0;
        data_sel  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!found && valid_in[i] && wait_cnt[i] == CNT_MAX) begin
                found     = 1'b1;
                ovr_hit   = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        // Upper half of the ring (ptr..N-1), then wrap to the bottom
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!found && valid_in[i] && SEL_W'(i) >= ptr) begin
                found     = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!found && valid_in[i]) begin
                found     = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        any_grant = found & reset & can_accept;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (SEL_W'(i) == grant_idx) begin
                grant[i] = any_grant;
                data_sel = data_in[i*DATAW +: DATAW];
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            sel_out    <= '0;
            starve_out <= 1'b0;
            ptr        <= '0;
        end else if (can_accept) begin
            valid_out <= any_grant;
            if (any_grant) begin
                data_out   <= data_sel;
                sel_out    <= grant_idx;
                starve_out <= ovr_hit;
                ptr        <= ptr_nxt;
            end
        end
    end

    // Per-input wait counters; frozen while the output is stalled
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!reset || grant[i] || !valid_in[i]) begin
                wait_cnt[i] <= '0;
            end else if (can_accept && wait_cnt[i] != CNT_MAX) begin
                wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    a_ready_onehot: assert property (
        @(posedge clk) disable iff (!reset) $onehot0(ready_in));

    a_out_stable: assert property (
        @(posedge clk) disable iff (!reset)
        valid_out && !ready_out |=> $stable(data_out));

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_hold
        a_valid_hold: assert property (
            @(posedge clk) disable iff (!reset)
            valid_in[g] && !ready_in[g] |=> valid_in[g]);
    end

endmodule

// File: tb/tb_alu_commit_arbiter.sv
// tb_alu_commit_arbiter: directed vectors, expected commits queued
// by the stimulus and popped by an output monitor.
module tb_alu_commit_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MW = 2;
    localparam int SW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
        logic          starve;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    valid_in = '0;
    logic [N*DW-1:0] data_in = '0;
    logic [N-1:0]    ready_in;
    logic            valid_out;
    logic [DW-1:0]   data_out;
    logic            ready_out = 1'b1;
    logic [SW-1:0]   sel_out;
    logic            starve_out;

    logic [DW-1:0]   src [N][$];
    logic [N-1:0]    hs = '0;
    exp_t            exp_q [$];
    exp_t            mon_e;
    int              n_vec = 0;
    int              n_bad = 0;

    alu_commit_arbiter #(
        .NUM_INPUTS(N),
        .DATAW(DW),
        .MAX_WAIT(MW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .data_in(data_in),
        .ready_in(ready_in),
        .valid_out(valid_out),
        .data_out(data_out),
        .ready_out(ready_out),
        .sel_out(sel_out),
        .starve_out(starve_out)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic put(int i, logic [DW-1:0] d);
        src[i].push_back(d);
    endtask

    task automatic expect_out(logic [DW-1:0] d, logic [SW-1:0] s, logic st);
        exp_t e;
        e.data   = d;
        e.sel    = s;
        e.starve = st;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++)
            @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Upstream sources: hold each payload until handshaked
    always @(negedge clk) hs = valid_in & ready_in;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (hs[i]) void'(src[i].pop_front());
        #2;
        for (int i = 0; i < N; i++) begin
            valid_in[i] = src[i].size() != 0;
            data_in[i*DW +: DW] = (src[i].size() != 0) ? src[i][0] : '0;
        end
    end

    // Output monitor: every accepted beat must match the queue head
    always @(negedge clk) begin
        if (reset && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL out_unexpected: got data %h sel %0d, expected none",
                         data_out, sel_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("out", 32'({data_out, sel_out, starve_out}), 32'(mon_e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with every input requesting
        put(0, 16'h0100);
        put(1, 16'h1100);
        put(2, 16'h2100);
        put(3, 16'h3100);
        expect_out(16'h0100, 2'd0, 1'b0);
        expect_out(16'h1100, 2'd1, 1'b0);
        expect_out(16'h2100, 2'd2, 1'b1);
        expect_out(16'h3100, 2'd3, 1'b1);
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ready_in", 32'(ready_in), 32'd0);
            check("rst_valid_out", 32'(valid_out), 32'd0);
            check("rst_sel_out", 32'(sel_out), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        wait_drain(20);

        // Round-robin between inputs 0 and 1
        for (int k = 0; k < 3; k++) begin
            put(0, 16'hA000 + 16'(k));
            put(1, 16'hB000 + 16'(k));
            expect_out(16'hA000 + 16'(k), 2'd0, 1'b0);
            expect_out(16'hB000 + 16'(k), 2'd1, 1'b0);
        end
        @(posedge clk);
        repeat (6) begin
            @(negedge clk);
            check("rr_tput", 32'(valid_out), 32'd1);
        end
        wait_drain(20);

        // Backpressure for 4 cycles, then back-to-back transfer
        put(0, 16'h00A5);
        put(0, 16'h00A6);
        expect_out(16'h00A5, 2'd0, 1'b0);
        expect_out(16'h00A6, 2'd0, 1'b0);
        @(posedge clk); #1;
        ready_out = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("bp_valid", 32'(valid_out), 32'd1);
            check("bp_data", 32'(data_out), 32'h00A5);
            check("bp_ready_in", 32'(ready_in), 32'd0);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        @(negedge clk);
        check("bp_b2b_grant", 32'(ready_in), 32'b0001);
        @(negedge clk);
        check("bp_no_bubble", 32'(valid_out), 32'd1);
        wait_drain(20);

        // Park ptr at 0, then input 2 loses to 0 and 1 until override
        put(3, 16'h3C00);
        expect_out(16'h3C00, 2'd3, 1'b0);
        wait_drain(20);
        for (int k = 0; k < 3; k++) begin
            put(0, 16'hD000 + 16'(k));
            put(1, 16'hE000 + 16'(k));
        end
        put(2, 16'h2C01);
        expect_out(16'hD000, 2'd0, 1'b0);
        expect_out(16'hE000, 2'd1, 1'b0);
        expect_out(16'h2C01, 2'd2, 1'b1);
        expect_out(16'hD001, 2'd0, 1'b1);
        expect_out(16'hE001, 2'd1, 1'b1);
        expect_out(16'hD002, 2'd0, 1'b0);
        expect_out(16'hE002, 2'd1, 1'b0);
        wait_drain(30);

        // Park ptr at 3, then inputs 1 and 2 reach the limit together
        put(2, 16'h2B00);
        expect_out(16'h2B00, 2'd2, 1'b0);
        wait_drain(20);
        put(0, 16'h5000);
        put(0, 16'h5001);
        put(1, 16'h5100);
        put(2, 16'h5200);
        put(3, 16'h5300);
        expect_out(16'h5300, 2'd3, 1'b0);
        expect_out(16'h5000, 2'd0, 1'b0);
        expect_out(16'h5100, 2'd1, 1'b1);
        expect_out(16'h5200, 2'd2, 1'b1);
        expect_out(16'h5001, 2'd0, 1'b1);
        wait_drain(30);

        // Reset while an entry is stalled at the output
        put(0, 16'h6000);
        put(0, 16'h6001);
        put(1, 16'h6100);
        put(3, 16'h6300);
        expect_out(16'h6100, 2'd1, 1'b0);
        @(posedge clk); #1;
        ready_out = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", 32'(valid_out), 32'd1);
        check("mid_pre_sel", 32'(sel_out), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_valid", 32'(valid_out), 32'd0);
        check("mid_rst_ready_in", 32'(ready_in), 32'd0);
        check("mid_rst_sel", 32'(sel_out), 32'd0);
        expect_out(16'h6000, 2'd0, 1'b0);
        expect_out(16'h6300, 2'd3, 1'b0);
        expect_out(16'h6001, 2'd0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        ready_out = 1'b1;
        wait_drain(20);

        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 32'(valid_out), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_commit_arbiter.md
Name: alu_commit_arbiter

Overview:
- Per-block commit arbiter that merges response streams from ALU sub-units (integer, mul/div, future units) onto one registered commit stream.
- Sits between the sub-unit commit outputs and the gather unit.
- Arbitration is round-robin with a starvation guard, so a long-latency unit's results are never stranded behind a continuous stream of single-cycle integer results.
- Provides full-throughput output buffering: one grant per cycle when downstream is ready.

Parameters:
- NUM_INPUTS, 2, number of requesting sub-units (≥1); input 0 is the integer unit.
- DATAW, 64, width of each commit payload in bits.
- MAX_WAIT, 8, starvation threshold in cycles (≥1).
- SEL_W, `UP(`CLOG2(NUM_INPUTS)), width of the select output.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; state cleared on a clk edge while reset==0.
- valid_in  in  NUM_INPUTS  per-input request valid.
- data_in  in  NUM_INPUTS*DATAW  packed payloads; input i occupies bits [i*DATAW +: DATAW].
- ready_in  out  NUM_INPUTS  per-input accept; one-hot or zero.
- valid_out  out  1  registered output valid.
- data_out  out  DATAW  registered output payload.
- ready_out  in  1  downstream accept.
- sel_out  out  SEL_W  index of the input that produced the current data_out.
- starve_out  out  1  registered flag: the current output entry was granted by the starvation override.

Behaviour:
- Reset values (reset==0 at an edge):
  - valid_out=0, data_out=0, sel_out=0, starve_out=0.
  - RR pointer=0; all wait counters=0.
  - ready_in is forced to 0 while reset==0.
- can_accept = ~valid_out | ready_out. The output register loads only when can_accept is high.
- Grant (combinational, gated by can_accept):
  - If any wait counter == MAX_WAIT, grant the lowest-index such input that has valid_in=1. This is the starvation override.
  - Otherwise, grant the first valid input scanning from ptr, ptr+1, … modulo NUM_INPUTS.
  - No valid inputs → no grant.
- ready_in[i] = grant[i]. It may depend combinationally on valid_in and ready_out. Inputs must hold valid/data stable until accepted.
- Transfer on input i when valid_in[i] & ready_in[i]. The next cycle shows:
  - valid_out=1, data_out=data_in[i], sel_out=i.
  - starve_out=1 if the override selected the input, else 0.
- Latency: exactly 1 cycle, input accept to valid_out.
- Throughput: 1 transfer/cycle while ready_out=1.
- Output hold: valid_out=1 & ready_out=0 → data_out, sel_out and starve_out hold; no grant.
- Output drain: if ready_out=1 and there is no new grant, valid_out→0. data_out holds its stale value.
- RR pointer: on a grant to i, ptr ← (i+1) mod NUM_INPUTS. This applies for both normal and override grants. No grant → ptr unchanged.
- Wait counter[i]:
  - Cleared when grant[i] or valid_in[i]=0.
  - Else incremented when can_accept=1 (lost arbitration), saturating at MAX_WAIT.
  - Else (output stalled) held.
- Simultaneous events:
  - A new grant in the same cycle as the output handshake is allowed; it is a back-to-back transfer with no bubble.
  - Several inputs at MAX_WAIT → lowest index wins; the others keep MAX_WAIT and win in later cycles.
- NUM_INPUTS=1: pass-through register. ptr and counters are constant 0, and starve_out stays 0.
- Reset mid-operation: an in-flight output entry is dropped (valid_out=0). Upstream must re-present its requests after reset releases.
- Assertions (simulation only):
  - ready_in is one-hot or zero.
  - No valid_in deassertion without a handshake.
  - data_out is stable while valid_out & ~ready_out.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all valid_in=1 → ready_in=0, valid_out=0, sel_out=0. First grant after release goes to input 0.
- Round-robin, NUM_INPUTS=2, both valid continuously, ready_out=1 → sel_out sequence 0,1,0,1…, one transfer per cycle, starve_out always 0.
- Backpressure: ready_out=0 for 4 cycles with valid_out=1, data_out=0xA5 → data_out stays 0xA5, ready_in=0. Then ready_out=1 → the next entry appears the following cycle with no bubble.
- Starvation, NUM_INPUTS=3, MAX_WAIT=2, ptr forced so input 2 keeps losing (inputs 0 and 1 re-request every cycle) → input 2 is granted within 3 cycles of asserting valid, with starve_out=1. Its counter then reads 0.
- Simultaneous override: inputs 1 and 2 both at MAX_WAIT and valid → input 1 is granted first, input 2 on the next accept cycle. Both have starve_out=1.
- Reset mid-stream: assert reset=0 while valid_out=1 & ready_out=0 → next cycle valid_out=0, ptr=0, counters=0. No stale entry appears after release.
